lfsr_checker: RTL and testbench

//  Receive-side PRBS checker matching the 16-bit byte-output LFSR generator
//  (taps 15,6,4,3, shift left, feedback into bit 0).

---
 rtl/lfsr_checker_if.sv | 33 +++
 rtl/lfsr_checker.sv | 128 ++++++++++++
 tb/tb_lfsr_checker.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_checker_if.sv
// rtl/lfsr_checker_if.sv - receive-byte stream and checker status bundle for lfsr_checker
// o_Bit_Err_Count is present only when LFSR_CHK_BITERR_EN is defined.
interface lfsr_checker_if #(
    parameter int ERR_W = 16
);
    logic             i_RX_DV;
    logic [7:0]       i_RX_Byte;
    logic             i_Clear;
    logic             o_Locked;
    logic             o_Err_Pulse;
    logic [ERR_W-1:0] o_Err_Count;
`ifdef LFSR_CHK_BITERR_EN
    logic [ERR_W-1:0] o_Bit_Err_Count;

    modport master (
        output i_RX_DV, i_RX_Byte, i_Clear,
        input  o_Locked, o_Err_Pulse, o_Err_Count, o_Bit_Err_Count
    );
    modport slave (
        input  i_RX_DV, i_RX_Byte, i_Clear,
        output o_Locked, o_Err_Pulse, o_Err_Count, o_Bit_Err_Count
    );
`else
    modport master (
        output i_RX_DV, i_RX_Byte, i_Clear,
        input  o_Locked, o_Err_Pulse, o_Err_Count
    );
    modport slave (
        input  i_RX_DV, i_RX_Byte, i_Clear,
        output o_Locked, o_Err_Pulse, o_Err_Count
    );
`endif
endinterface

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising PRBS byte checker (x^16 LFSR, taps 15,6,4,3)
// Optional macro LFSR_CHK_BITERR_EN adds the saturating bit-error counter.
module lfsr_checker #(
    parameter int LOCK_BYTES  = 16,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_W       = 16
) (
    input  logic         i_Clock,
    input  logic         i_Rst_L,
    lfsr_checker_if.slave io_Rx
);
    localparam int FILL_W = $clog2(LOCK_BYTES + 1);
    localparam int MISS_W = $clog2(LOSS_THRESH + 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t            r_State;
    state_t            w_State_Nxt;
    logic [15:0]       r_Ref;
    logic [15:0]       w_Ref_Nxt;
    logic [FILL_W-1:0] r_Fill;
    logic [FILL_W-1:0] w_Fill_Nxt;
    logic [MISS_W-1:0] r_Miss;
    logic [MISS_W-1:0] w_Miss_Nxt;
    logic              r_Err_Pulse;
    logic              w_Err_Inc;
    logic [ERR_W-1:0]  r_Err_Count;

    logic              w_Fb;
    logic [7:0]        w_Expect;
    logic              w_Mismatch;

    assign w_Fb       = r_Ref[15] ^ r_Ref[6] ^ r_Ref[4] ^ r_Ref[3];
    assign w_Expect   = {r_Ref[6:0], w_Fb};
    assign w_Mismatch = (io_Rx.i_RX_Byte != w_Expect);

    always_comb begin
        w_State_Nxt = r_State;
        w_Ref_Nxt   = r_Ref;
        w_Fill_Nxt  = r_Fill;
        w_Miss_Nxt  = r_Miss;
        w_Err_Inc   = 1'b0;
        if (io_Rx.i_RX_DV) begin
            case (r_State)
                SEARCH: begin
                    w_Ref_Nxt = {r_Ref[14:0], io_Rx.i_RX_Byte[0]};
                    if (r_Fill == FILL_W'(LOCK_BYTES - 1)) begin
                        // An all-zero window is the LFSR's dead state; refill instead of locking.
                        w_Fill_Nxt = '0;
                        if (w_Ref_Nxt != 16'h0000) begin
                            w_State_Nxt = LOCKED;
                            w_Miss_Nxt  = '0;
                        end
                    end else begin
                        w_Fill_Nxt = r_Fill + 1'b1;
                    end
                end
                LOCKED: begin
                    w_Ref_Nxt = {r_Ref[14:0], w_Fb};
                    if (w_Mismatch) begin
                        w_Err_Inc = 1'b1;
                        if (r_Miss == MISS_W'(LOSS_THRESH - 1)) begin
                            w_State_Nxt = SEARCH;
                            w_Fill_Nxt  = '0;
                            w_Miss_Nxt  = '0;
                        end else begin
                            w_Miss_Nxt = r_Miss + 1'b1;
                        end
                    end else begin
                        w_Miss_Nxt = '0;
                    end
                end
                default: w_State_Nxt = SEARCH;
            endcase
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State     <= SEARCH;
            r_Ref       <= '0;
            r_Fill      <= '0;
            r_Miss      <= '0;
            r_Err_Pulse <= 1'b0;
        end else begin
            r_State     <= w_State_Nxt;
            r_Ref       <= w_Ref_Nxt;
            r_Fill      <= w_Fill_Nxt;
            r_Miss      <= w_Miss_Nxt;
            r_Err_Pulse <= w_Err_Inc;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Err_Count <= '0;
        end else if (io_Rx.i_Clear) begin
            r_Err_Count <= '0;
        end else if (w_Err_Inc && (r_Err_Count != {ERR_W{1'b1}})) begin
            r_Err_Count <= r_Err_Count + 1'b1;
        end
    end

`ifdef LFSR_CHK_BITERR_EN
    logic [ERR_W-1:0] r_Bit_Err_Count;
    logic [3:0]       w_Pop;
    logic [ERR_W:0]   w_Bit_Sum;

    assign w_Pop     = 4'($countones(io_Rx.i_RX_Byte ^ w_Expect));
    assign w_Bit_Sum = {1'b0, r_Bit_Err_Count} + (ERR_W + 1)'(w_Pop);

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Bit_Err_Count <= '0;
        end else if (io_Rx.i_Clear) begin
            r_Bit_Err_Count <= '0;
        end else if (w_Err_Inc) begin
            r_Bit_Err_Count <= w_Bit_Sum[ERR_W] ? {ERR_W{1'b1}} : w_Bit_Sum[ERR_W-1:0];
        end
    end

    assign io_Rx.o_Bit_Err_Count = r_Bit_Err_Count;
`endif

    assign io_Rx.o_Locked    = (r_State == LOCKED);
    assign io_Rx.o_Err_Pulse = r_Err_Pulse;
    assign io_Rx.o_Err_Count = r_Err_Count;
endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - model-based bench for lfsr_checker (default and narrow-counter instances)
module tb_lfsr_checker;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    lfsr_checker_if #(.ERR_W(16)) ifa ();
    lfsr_checker_if #(.ERR_W(4))  ifb ();

    lfsr_checker #(.LOCK_BYTES(16), .LOSS_THRESH(4), .ERR_W(16)) dut_a (
        .i_Clock(clk), .i_Rst_L(rst_n), .io_Rx(ifa));
    lfsr_checker #(.LOCK_BYTES(16), .LOSS_THRESH(100), .ERR_W(4)) dut_b (
        .i_Clock(clk), .i_Rst_L(rst_n), .io_Rx(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          loss;
        int          maxv;
        bit          locked;
        logic [15:0] hist;
        int          fill;
        int          miss;
        int          errc;
        int          biterr;
        bit          pulse;
    } mdl_t;

    mdl_t        ma, mb;
    logic [15:0] g;

    function automatic logic [15:0] gen_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[6] ^ s[4] ^ s[3]};
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic mreset(inout mdl_t m);
        m.locked = 0; m.hist = '0; m.fill = 0; m.miss = 0;
        m.errc = 0; m.biterr = 0; m.pulse = 0;
    endtask

    task automatic mstep(inout mdl_t m, input bit dv, input logic [7:0] b, input bit clr);
        logic [15:0] nxt;
        m.pulse = 0;
        if (dv) begin
            if (!m.locked) begin
                m.hist = {m.hist[14:0], b[0]};
                m.fill = m.fill + 1;
                if (m.fill == 16) begin
                    m.fill = 0;
                    if (m.hist != 0) begin m.locked = 1; m.miss = 0; end
                end
            end else begin
                nxt = gen_next(m.hist);
                m.hist = nxt;
                if (b == nxt[7:0]) begin
                    m.miss = 0;
                end else begin
                    m.pulse  = 1;
                    m.errc   = imin(m.errc + 1, m.maxv);
                    m.biterr = imin(m.biterr + $countones(b ^ nxt[7:0]), m.maxv);
                    m.miss   = m.miss + 1;
                    if (m.miss >= m.loss) begin m.locked = 0; m.fill = 0; m.miss = 0; end
                end
            end
        end
        if (clr) begin m.errc = 0; m.biterr = 0; end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        chk("a_locked", 32'(ifa.o_Locked), 32'(ma.locked));
        chk("a_pulse",  32'(ifa.o_Err_Pulse), 32'(ma.pulse));
        chk("a_errc",   32'(ifa.o_Err_Count), 32'(ma.errc));
        chk("b_locked", 32'(ifb.o_Locked), 32'(mb.locked));
        chk("b_pulse",  32'(ifb.o_Err_Pulse), 32'(mb.pulse));
        chk("b_errc",   32'(ifb.o_Err_Count), 32'(mb.errc));
`ifdef LFSR_CHK_BITERR_EN
        chk("a_biterr", 32'(ifa.o_Bit_Err_Count), 32'(ma.biterr));
        chk("b_biterr", 32'(ifb.o_Bit_Err_Count), 32'(mb.biterr));
`endif
    end

    task automatic step(input bit dv, input logic [7:0] b, input bit clr);
        @(negedge clk);
        ifa.i_RX_DV = dv; ifa.i_RX_Byte = b; ifa.i_Clear = clr;
        ifb.i_RX_DV = dv; ifb.i_RX_Byte = b; ifb.i_Clear = clr;
        mstep(ma, dv, b, clr);
        mstep(mb, dv, b, clr);
    endtask

    task automatic send_gen(input logic [7:0] flip, input bit clr);
        g = gen_next(g);
        step(1'b1, g[7:0] ^ flip, clr);
    endtask

    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    initial begin
        logic [15:0] t;
        ma.loss = 4;   ma.maxv = 65535;
        mb.loss = 100; mb.maxv = 15;
        mreset(ma); mreset(mb);
        rst_n = 1'b0;
        ifa.i_RX_DV = 0; ifa.i_RX_Byte = 0; ifa.i_Clear = 0;
        ifb.i_RX_DV = 0; ifb.i_RX_Byte = 0; ifb.i_Clear = 0;
        g = 16'hACE1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        settle();
        chk("rst_locked", 32'(ifa.o_Locked), 32'h0);
        chk("rst_pulse",  32'(ifa.o_Err_Pulse), 32'h0);
        chk("rst_errc",   32'(ifa.o_Err_Count), 32'h0);

        t = gen_next(16'hACE1); chk("gen_b0", 32'(t[7:0]), 32'hC2);
        t = gen_next(t);        chk("gen_b1", 32'(t[7:0]), 32'h85);
        t = gen_next(t);        chk("gen_b2", 32'(t[7:0]), 32'h0B);

        // Acquisition from the generator stream
        for (int i = 0; i < 15; i++) send_gen(8'h00, 1'b0);
        settle();
        chk("lock_after15", 32'(ifa.o_Locked), 32'h0);
        send_gen(8'h00, 1'b0);
        settle();
        chk("lock_after16_a", 32'(ifa.o_Locked), 32'h1);
        chk("lock_after16_b", 32'(ifb.o_Locked), 32'h1);
        for (int i = 0; i < 100; i++) send_gen(8'h00, 1'b0);
        settle();
        chk("clean_errc", 32'(ifa.o_Err_Count), 32'h0);

        // Single inverted byte, then a good one
        send_gen(8'hFF, 1'b0);
        settle();
        chk("inv_pulse", 32'(ifa.o_Err_Pulse), 32'h1);
        chk("inv_errc",  32'(ifa.o_Err_Count), 32'h1);
`ifdef LFSR_CHK_BITERR_EN
        chk("inv_biterr", 32'(ifa.o_Bit_Err_Count), 32'h8);
`endif
        send_gen(8'h00, 1'b0);
        settle();
        chk("good_pulse", 32'(ifa.o_Err_Pulse), 32'h0);
        chk("good_errc",  32'(ifa.o_Err_Count), 32'h1);

        // Three misses then a hit keep lock; four in a row drop it
        for (int i = 0; i < 3; i++) send_gen(8'h01, 1'b0);
        send_gen(8'h00, 1'b0);
        settle();
        chk("miss3_locked", 32'(ifa.o_Locked), 32'h1);
        chk("miss3_errc",   32'(ifa.o_Err_Count), 32'h4);
        for (int i = 0; i < 4; i++) send_gen(8'h10, 1'b0);
        settle();
        chk("miss4_a_locked", 32'(ifa.o_Locked), 32'h0);
        chk("miss4_b_locked", 32'(ifb.o_Locked), 32'h1);
        chk("miss4_errc",     32'(ifa.o_Err_Count), 32'h8);
        step(1'b0, 8'h00, 1'b0);

        // All-zero stream never locks, a generator stream then does
        @(negedge clk); rst_n = 1'b0; mreset(ma); mreset(mb);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 16; i++) step(1'b1, 8'h00, 1'b0);
        settle();
        chk("zero_locked_a", 32'(ifa.o_Locked), 32'h0);
        chk("zero_locked_b", 32'(ifb.o_Locked), 32'h0);
        for (int i = 0; i < 16; i++) send_gen(8'h00, 1'b0);
        settle();
        chk("relock_a", 32'(ifa.o_Locked), 32'h1);

        // Saturation of the 4-bit counter and clear-beats-increment
        for (int i = 0; i < 20; i++) send_gen(8'hFF, 1'b0);
        settle();
        chk("sat_b_errc", 32'(ifb.o_Err_Count), 32'hF);
        send_gen(8'h80, 1'b1);
        settle();
        chk("clr_b_errc",  32'(ifb.o_Err_Count), 32'h0);
        chk("clr_b_pulse", 32'(ifb.o_Err_Pulse), 32'h1);
        chk("clr_b_lock",  32'(ifb.o_Locked), 32'h1);
        for (int i = 0; i < 3; i++) send_gen(8'h00, 1'b0);

        // Asynchronous reset between strobes, then full refill needed
        @(negedge clk);
        ifa.i_RX_DV = 0; ifb.i_RX_DV = 0;
        mstep(ma, 1'b0, 8'h00, 1'b0); mstep(mb, 1'b0, 8'h00, 1'b0);
        #3 rst_n = 1'b0;
        mreset(ma); mreset(mb);
        #1;
        chk("arst_b_locked", 32'(ifb.o_Locked), 32'h0);
        chk("arst_b_errc",   32'(ifb.o_Err_Count), 32'h0);
        chk("arst_b_pulse",  32'(ifb.o_Err_Pulse), 32'h0);
        chk("arst_a_locked", 32'(ifa.o_Locked), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 15; i++) send_gen(8'h00, 1'b0);
        settle();
        chk("arst_15_locked", 32'(ifb.o_Locked), 32'h0);
        send_gen(8'h00, 1'b0);
        settle();
        chk("arst_16_locked", 32'(ifb.o_Locked), 32'h1);
        step(1'b0, 8'h00, 1'b0);
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
